led_mode_ctrl: RTL
==================

Name: led_mode_ctrl

Overview:
- Sequencing controller for the 4-LED bank (active-low).
- One debounced push-button steps the display through four modes: run-left, run-right, blink and hold.
- An internal tick generator paces pattern updates, so no external divided clock is needed.
- Sits at top level between the board key, the board clock and the LED pins, and replaces the fixed single-mode flowing-LED chain.

Parameters:
- TICK_CNT, 25_000_000, clk cycles per pattern step (0.5 s at 50 MHz); must be >= 2.
- DEB_CNT, 1_000_000, clk cycles the synced key must hold a new level before it is accepted (20 ms at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset: synchronous, active-low; sampled on rising clk only
- key_n  input  1  raw push-button, asynchronous, low = pressed
- led  output  4  LED drive, low = lit
- mode  output  2  current mode (debug): 0 RUN_L, 1 RUN_R, 2 BLINK, 3 HOLD

Behaviour:
- Clocking and reset:
  - Single clock domain, all state in flops on rising clk.
  - rst_n=0 at an edge sets: led=4'b1110, mode=0, tick counter=0, debounce counter=0, sync flops=1, key_stable=1, key_evt=0.
  - Reset mid-operation takes effect at the next edge and overrides everything, including a pending key_evt.
- Key path:
  - key_n passes through a 2-flop synchronizer to give key_s.
  - Debounce counter increments while key_s != key_stable and clears whenever they are equal.
  - When the counter reaches DEB_CNT-1 with key_s still differing: key_stable <= key_s and the counter clears.
  - key_evt is a registered 1-cycle pulse on a key_stable 1->0 transition, i.e. the cycle after key_stable falls.
  - Holding the key produces exactly one event. Release produces no event.
  - Bounces shorter than DEB_CNT cycles produce no event.
- Tick generator:
  - Counter runs 0..TICK_CNT-1, then wraps to 0.
  - tick is a 1-cycle internal pulse in the cycle the count equals TICK_CNT-1.
  - Counter runs continuously in every mode, HOLD included.
- Mode FSM, advanced by key_evt only:
  - RUN_L -> RUN_R -> BLINK -> HOLD -> RUN_L.
  - On a mode change, at the same edge: tick counter <= 0, and led loads the new mode's entry pattern.
  - Entry patterns: RUN_L 4'b1110, RUN_R 4'b0111, BLINK 4'b0000. HOLD keeps the current led value.
- Per-tick update, applied only when there is no key_evt in that cycle:
  - RUN_L: led <= {led[2:0], led[3]}, giving 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - RUN_R: led <= {led[0], led[3:1]}, giving 0111 -> 1011 -> 1101 -> 1110 -> 0111.
  - BLINK: led <= ~led, alternating 0000 and 1111.
  - HOLD: led unchanged.
- Simultaneous key_evt and tick: key_evt wins. The mode advances, the entry pattern loads and the tick counter clears; the tick is discarded.
- Outputs are registered, with no combinational path from key_n or rst_n to led or mode.
- Latency: mode and led change exactly 1 cycle after key_evt; key_evt occurs DEB_CNT+3 cycles after the falling edge of a clean key_n.

Decomposition:
- Package led_ctrl_pkg holds:
  - mode encodings MODE_RUN_L=2'd0, MODE_RUN_R=2'd1, MODE_BLINK=2'd2, MODE_HOLD=2'd3;
  - entry patterns PAT_RUN_L=4'b1110, PAT_RUN_R=4'b0111, PAT_BLINK=4'b0000;
  - LED_OFF=4'b1111.
- One sub-module, key_debounce (clk, rst_n, key_n, key_evt), containing the synchronizer, debounce counter and edge pulse. The tick counter, FSM and pattern register stay in led_mode_ctrl.

Test Plan (TICK_CNT=4, DEB_CNT=3):
- Reset and run-left: hold rst_n=0 for 3 cycles, then release; key idle -> led=1110, mode=0 right after reset; then 1101, 1011, 0111, 1110 at 4-cycle intervals.
- Clean press: drive key_n low for 20 cycles -> exactly one key_evt, DEB_CNT+3 cycles after the fall; mode=1 and led=0111 one cycle later; tick restarts and the next step to 1011 follows 4 cycles after that.
- Bounce rejection: toggle key_n low/high with 2-cycle pulses for 12 cycles, then leave it high -> no key_evt, mode and pattern continue unchanged.
- Full cycle and wrap: four clean presses -> mode 0->1->2->3->0. BLINK alternates 0000/1111 every 4 cycles. HOLD freezes led for at least 12 cycles. Returning to RUN_L reloads 1110.
- Collision: time the press so key_evt coincides with tick=1 while in RUN_L -> mode=1, led=0111, no rotation applied, counter restarts from 0.
- Synchronous reset mid-BLINK: assert rst_n=0 for 1 edge while led=0000 -> at that edge led=1110 and mode=0. Asserting rst_n without a clk edge must not change the outputs.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and LED patterns for the LED sequencing controller.
// LEDs are active-low: a 0 bit is a lit LED.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN_L = 2'd0,
    MODE_RUN_R = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  localparam logic [3:0] PAT_RUN_L = 4'b1110;
  localparam logic [3:0] PAT_RUN_R = 4'b0111;
  localparam logic [3:0] PAT_BLINK = 4'b0000;
  localparam logic [3:0] LED_OFF   = 4'b1111;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

  // HOLD has no entry pattern of its own; it freezes whatever is showing.
  function automatic logic [3:0] entry_pattern(input mode_e m, input logic [3:0] cur);
    case (m)
      MODE_RUN_L: return PAT_RUN_L;
      MODE_RUN_R: return PAT_RUN_R;
      MODE_BLINK: return PAT_BLINK;
      default:    return cur;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// Push-button front end: 2-flop synchronizer, level debounce and a one-cycle
// press event issued the cycle after the debounced level falls.
module key_debounce #(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_evt
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic          sync1_q, sync1_d;
  logic          key_s_q, key_s_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = key_n;
    key_s_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;
    // A new level is accepted only after DEB_CNT consecutive differing samples.
    if (key_s_q != stable_q) begin
      if (cnt_q == CW'(DEB_CNT - 1)) begin
        stable_d = key_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    evt_d = stable_dly_q & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      key_s_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      evt_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      key_s_q      <= key_s_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      evt_q        <= evt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign key_evt = evt_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Four-LED sequencer: a debounced key steps RUN_L -> RUN_R -> BLINK -> HOLD,
// and a free-running tick counter paces the pattern within each mode.
module led_mode_ctrl #(
  parameter int TICK_CNT = 25_000_000,
  parameter int DEB_CNT  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic [3:0] led,
  output logic [1:0] mode
);

  import led_ctrl_pkg::*;

  localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

  logic          key_evt;
  logic          tick;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  mode_e         mode_q, mode_d;
  logic [3:0]    led_q, led_d;

  key_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .key_evt (key_evt)
  );

  assign tick = (tick_cnt_q == TW'(TICK_CNT - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    mode_d     = mode_q;
    led_d      = led_q;
    // A key event outranks a coincident tick: that tick is simply dropped.
    if (key_evt) begin
      mode_d     = next_mode(mode_q);
      tick_cnt_d = '0;
      led_d      = entry_pattern(mode_d, led_q);
    end else if (tick) begin
      case (mode_q)
        MODE_RUN_L: led_d = {led_q[2:0], led_q[3]};
        MODE_RUN_R: led_d = {led_q[0], led_q[3:1]};
        MODE_BLINK: led_d = led_q ^ LED_OFF;
        default:    led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      mode_q     <= MODE_RUN_L;
      led_q      <= PAT_RUN_L;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
